// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one pipelined 17-bit fmul among NREQ requesters.
// Define FMUL_ARBITER_PERF_EN to add the perf_issued / perf_stall counters.

module fmul #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic [16:0] x,
   input  logic [16:0] y,
   output logic [16:0] r
);
   localparam int unsigned FW = 17;
   localparam int unsigned EW = 10;

   logic [1:0]    xe, ye;
   logic          s;
   logic [7:0]    mx, my;
   logic [15:0]   p;
   logic          norm;
   logic [7:0]    m_trunc;
   logic          guard, sticky, rnd;
   logic [8:0]    m_rnd;
   logic [EW-1:0] e_b;
   logic [FW-1:0] r_c;
   logic [LATENCY-1:0][FW-1:0] pipe;

   // Exception table first, then normal product with round-to-nearest-even
   always_comb begin
      xe      = x[16:15];
      ye      = y[16:15];
      s       = x[14] ^ y[14];
      mx      = {1'b1, x[6:0]};
      my      = {1'b1, y[6:0]};
      p       = 16'(mx) * 16'(my);
      norm    = p[15];
      m_trunc = norm ? p[15:8] : p[14:7];
      guard   = norm ? p[7] : p[6];
      sticky  = norm ? (|p[6:0]) : (|p[5:0]);
      rnd     = guard & (sticky | m_trunc[0]);
      m_rnd   = {1'b0, m_trunc} + 9'(rnd);
      // biased sum still carries one extra bias of 63
      e_b     = EW'(x[13:7]) + EW'(y[13:7]) + EW'(norm) + EW'(m_rnd[8]);
      r_c     = '0;
      if (xe == 2'b11 || ye == 2'b11 || (xe == 2'b00 && ye == 2'b10) ||
          (xe == 2'b10 && ye == 2'b00)) begin
         r_c = {2'b11, s, 14'd0};
      end else if (xe == 2'b10 || ye == 2'b10) begin
         r_c = {2'b10, s, 14'd0};
      end else if (xe == 2'b00 || ye == 2'b00) begin
         r_c = {2'b00, s, 14'd0};
      end else if (e_b > EW'(190)) begin
         r_c = {2'b10, s, 14'd0};
      end else if (e_b < EW'(63)) begin
         r_c = {2'b00, s, 14'd0};
      end else begin
         r_c = {2'b01, s, 7'(e_b - EW'(63)), m_rnd[6:0]};
      end
   end

   // Datapath pipe is intentionally unreset; the tag pipe qualifies it
   always_ff @(posedge clk) begin
      pipe[0] <= r_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign r = pipe[LATENCY-1];
endmodule

module fmul_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*17-1:0] req_x,
   input  logic [NREQ*17-1:0] req_y,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [16:0]        rsp_r,
   output logic               busy
`ifdef FMUL_ARBITER_PERF_EN
 , output logic [31:0]        perf_issued
 , output logic [31:0]        perf_stall
`endif
);
   localparam int unsigned FW = 17;
   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = IW + 1;

   logic [IW-1:0]              ptr;
   logic [IW-1:0]              ptr_nxt;
   logic [IW-1:0]              grant_idx;
   logic                       grant_any;
   logic [CW-1:0]              cand;
   logic [FW-1:0]              x_arr [NREQ];
   logic [FW-1:0]              y_arr [NREQ];
   logic [FW-1:0]              fmul_r;
   logic [LATENCY-1:0]         tag_v;
   logic [LATENCY-1:0][IW-1:0] tag_idx;

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         x_arr[i] = req_x[i*FW +: FW];
         y_arr[i] = req_y[i*FW +: FW];
      end
   end

   // First valid requester at or after the pointer, wrapping modulo NREQ
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      req_ready = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         cand = {1'b0, ptr} + CW'(k);
         if (cand >= CW'(NREQ)) begin
            cand = cand - CW'(NREQ);
         end
         if (!grant_any && req_valid[cand[IW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[IW-1:0];
         end
      end
      if (!rst_n) begin
         grant_any = 1'b0;
      end
      if (grant_any) begin
         req_ready[grant_idx] = 1'b1;
      end
      ptr_nxt = ptr;
      if (grant_any) begin
         ptr_nxt = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_nxt;
      end
   end

   fmul #(.LATENCY(LATENCY)) u_fmul (
      .clk (clk),
      .x   (x_arr[grant_idx]),
      .y   (y_arr[grant_idx]),
      .r   (fmul_r)
   );

   // Tag pipe mirrors the fmul depth; reset drops everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v   <= '0;
         tag_idx <= '0;
      end else begin
         tag_v[0]   <= grant_any;
         tag_idx[0] <= grant_idx;
         for (int i = 1; i < int'(LATENCY); i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (tag_v[LATENCY-1]) begin
         rsp_valid[tag_idx[LATENCY-1]] = 1'b1;
      end
   end

   assign rsp_r = tag_v[LATENCY-1] ? fmul_r : '0;
   assign busy  = |tag_v;

`ifdef FMUL_ARBITER_PERF_EN
   logic stall_c;
   assign stall_c = |(req_valid & ~req_ready);

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (grant_any && perf_issued != '1) begin
            perf_issued <= perf_issued + 32'd1;
         end
         if (stall_c && perf_stall != '1) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif
endmodule
